// File: rtl/id_issue.sv
// RV32I decode/issue stage: decodes the ALU subset and launches it into ex
// with a registered one-cycle ex_en pulse once the operands have settled.
module id_issue #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [XLEN-1:0] inst,
    input  logic [XLEN-1:0] inst_pc,
    input  logic            hold,
    input  logic            flush,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] imm,
    output logic            pc_en,
    output logic            imm_en,
    output logic [2:0]      aluop,
    output logic [RA_W-1:0] rs1,
    output logic [RA_W-1:0] rs2,
    output logic [RA_W-1:0] rd,
    output logic            rd_we,
    output logic            ex_en,
    output logic            illegal
);

    localparam logic [2:0] ALU_OR  = 3'd0;
    localparam logic [2:0] ALU_AND = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_ADD = 3'd3;
    localparam logic [2:0] ALU_SUB = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        FIRE
    } state_t;

    state_t state_q, state_d;

    logic            ready_q, ready_d;
    logic            ex_en_q, ex_en_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic            pc_en_q, pc_en_d;
    logic            imm_en_q, imm_en_d;
    logic [2:0]      aluop_q, aluop_d;
    logic [RA_W-1:0] rs1_q, rs1_d;
    logic [RA_W-1:0] rs2_q, rs2_d;
    logic [RA_W-1:0] rd_q, rd_d;
    logic            rd_we_q, rd_we_d;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_op, is_opi, is_lui, is_auipc;

    logic            dec_ok;
    logic [2:0]      dec_aluop;
    logic            dec_pc_en;
    logic            dec_imm_en;
    logic [XLEN-1:0] dec_imm;
    logic [RA_W-1:0] dec_rs1;
    logic [RA_W-1:0] dec_rs2;
    logic            xfer;

    assign opc      = inst[6:0];
    assign f3       = inst[14:12];
    assign f7       = inst[31:25];
    assign is_op    = (opc == 7'b0110011);
    assign is_opi   = (opc == 7'b0010011);
    assign is_lui   = (opc == 7'b0110111);
    assign is_auipc = (opc == 7'b0010111);
    assign xfer     = inst_valid & ready_q;

    always_comb begin
        dec_ok     = 1'b0;
        dec_aluop  = ALU_ADD;
        dec_pc_en  = 1'b0;
        dec_imm_en = 1'b0;
        dec_imm    = '0;
        dec_rs1    = RA_W'(inst[19:15]);
        dec_rs2    = '0;
        unique case (1'b1)
            is_op: begin
                dec_rs2 = RA_W'(inst[24:20]);
                unique case (f3)
                    3'b000: begin
                        dec_ok    = (f7 == 7'h00) || (f7 == 7'h20);
                        dec_aluop = f7[5] ? ALU_SUB : ALU_ADD;
                    end
                    3'b100: begin
                        dec_ok    = (f7 == 7'h00);
                        dec_aluop = ALU_XOR;
                    end
                    3'b110: begin
                        dec_ok    = (f7 == 7'h00);
                        dec_aluop = ALU_OR;
                    end
                    3'b111: begin
                        dec_ok    = (f7 == 7'h00);
                        dec_aluop = ALU_AND;
                    end
                    default: dec_ok = 1'b0;
                endcase
            end
            is_opi: begin
                dec_imm_en = 1'b1;
                dec_imm    = XLEN'($signed(inst[31:20]));
                unique case (f3)
                    3'b000: begin dec_ok = 1'b1; dec_aluop = ALU_ADD; end
                    3'b100: begin dec_ok = 1'b1; dec_aluop = ALU_XOR; end
                    3'b110: begin dec_ok = 1'b1; dec_aluop = ALU_OR;  end
                    3'b111: begin dec_ok = 1'b1; dec_aluop = ALU_AND; end
                    default: dec_ok = 1'b0;
                endcase
            end
            is_lui: begin
                dec_ok     = 1'b1;
                dec_imm_en = 1'b1;
                dec_rs1    = '0;
                dec_imm    = XLEN'($signed({inst[31:12], 12'h000}));
            end
            is_auipc: begin
                dec_ok     = 1'b1;
                dec_pc_en  = 1'b1;
                dec_imm_en = 1'b1;
                dec_rs1    = '0;
                dec_imm    = XLEN'($signed({inst[31:12], 12'h000}));
            end
            default: dec_ok = 1'b0;
        endcase
    end

    // ex_en is registered off FIRE so ex sees a glitch-free edge
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        pc_en_d   = pc_en_q;
        imm_en_d  = imm_en_q;
        aluop_d   = aluop_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        rd_we_d   = rd_we_q;
        illegal_d = xfer & ~dec_ok;
        unique case (state_q)
            IDLE: begin
                if (xfer && dec_ok) begin
                    state_d  = SETUP;
                    pc_d     = inst_pc;
                    imm_d    = dec_imm;
                    pc_en_d  = dec_pc_en;
                    imm_en_d = dec_imm_en;
                    aluop_d  = dec_aluop;
                    rs1_d    = dec_rs1;
                    rs2_d    = dec_rs2;
                    rd_d     = RA_W'(inst[11:7]);
                    rd_we_d  = (inst[11:7] != 5'd0);
                end
            end
            SETUP: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (!hold) begin
                    state_d = FIRE;
                end
            end
            FIRE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        ex_en_d = (state_q == FIRE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            ex_en_q   <= 1'b0;
            illegal_q <= 1'b0;
            pc_q      <= '0;
            imm_q     <= '0;
            pc_en_q   <= 1'b0;
            imm_en_q  <= 1'b0;
            aluop_q   <= 3'h0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            rd_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            ex_en_q   <= ex_en_d;
            illegal_q <= illegal_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            pc_en_q   <= pc_en_d;
            imm_en_q  <= imm_en_d;
            aluop_q   <= aluop_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            rd_we_q   <= rd_we_d;
        end
    end

    assign inst_ready = ready_q;
    assign ex_en      = ex_en_q;
    assign illegal    = illegal_q;
    assign pc         = pc_q;
    assign imm        = imm_q;
    assign pc_en      = pc_en_q;
    assign imm_en     = imm_en_q;
    assign aluop      = aluop_q;
    assign rs1        = rs1_q;
    assign rs2        = rs2_q;
    assign rd         = rd_q;
    assign rd_we      = rd_we_q;

endmodule

// File: tb/tb_id_issue.sv
// Bench for id_issue: directed and random instruction words against a
// decode model, with issue timing, hold, flush and reset scenarios.
module tb_id_issue;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pc_en;
        logic        imm_en;
        logic [2:0]  aluop;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_valid = 1'b0;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] inst = '0;
    logic [31:0] inst_pc = '0;
    logic        inst_ready;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pc_en;
    logic        imm_en;
    logic [2:0]  aluop;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        ex_en;
    logic        illegal;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    dec_t last = '0;
    dec_t dut_v;

    id_issue #(.XLEN(32), .RA_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst      (inst),
        .inst_pc   (inst_pc),
        .hold      (hold),
        .flush     (flush),
        .pc        (pc),
        .imm       (imm),
        .pc_en     (pc_en),
        .imm_en    (imm_en),
        .aluop     (aluop),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .rd_we     (rd_we),
        .ex_en     (ex_en),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign dut_v = {pc, imm, pc_en, imm_en, aluop, rs1, rs2, rd, rd_we};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Decode rules of the supported subset, written as a lookup of the ISA
    function automatic dec_t model(input logic [31:0] w, input logic [31:0] p,
                                   output bit ok);
        dec_t e;
        e       = '0;
        ok      = 1'b0;
        e.pc    = p;
        e.rd    = w[11:7];
        e.rd_we = (w[11:7] != 5'd0);
        e.rs1   = w[19:15];
        case (w[6:0])
            7'h33: begin
                e.rs2 = w[24:20];
                case ({w[31:25], w[14:12]})
                    {7'h00, 3'd0}: begin ok = 1; e.aluop = 3; end
                    {7'h20, 3'd0}: begin ok = 1; e.aluop = 4; end
                    {7'h00, 3'd4}: begin ok = 1; e.aluop = 2; end
                    {7'h00, 3'd6}: begin ok = 1; e.aluop = 0; end
                    {7'h00, 3'd7}: begin ok = 1; e.aluop = 1; end
                    default: ok = 0;
                endcase
            end
            7'h13: begin
                e.imm_en = 1;
                e.imm    = {{20{w[31]}}, w[31:20]};
                case (w[14:12])
                    3'd0: begin ok = 1; e.aluop = 3; end
                    3'd4: begin ok = 1; e.aluop = 2; end
                    3'd6: begin ok = 1; e.aluop = 0; end
                    3'd7: begin ok = 1; e.aluop = 1; end
                    default: ok = 0;
                endcase
            end
            7'h37: begin
                ok = 1; e.aluop = 3; e.rs1 = 0; e.imm_en = 1;
                e.imm = {w[31:12], 12'h000};
            end
            7'h17: begin
                ok = 1; e.aluop = 3; e.rs1 = 0; e.imm_en = 1; e.pc_en = 1;
                e.imm = {w[31:12], 12'h000};
            end
            default: ok = 0;
        endcase
        return e;
    endfunction

    // Handshake driver: call at a negedge, returns at the negedge after the transfer
    task automatic send(input logic [31:0] w, input logic [31:0] p,
                        input bit keep, output int xc);
        bit rdy;
        bit done;
        inst_valid = 1'b1;
        inst       = w;
        inst_pc    = p;
        done       = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            rdy = inst_ready;
            @(posedge clk);
            if (rdy) done = 1'b1;
            @(negedge clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: inst_ready low for 20 cycles, word %h", w);
        end
        xc = cyc;
        if (!keep) inst_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({dut_v, ex_en, illegal, inst_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h ex_en=%b illegal=%b ready=%b, want all 0",
                     dut_v, ex_en, illegal, inst_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (inst_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 0", inst_ready);
        end
        @(negedge clk);
        checks++;
        if (inst_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: got %b want 1", inst_ready);
        end
        last = '0;
    endtask

    task automatic test_directed();
        logic [31:0] words [8];
        logic [31:0] pcs   [8];
        logic [2:0]  ops   [8];
        dec_t e;
        bit   ok;
        int   xc;
        int   k;
        words = '{32'h002081B3, 32'h402081B3, 32'h0020E1B3, 32'h0020F1B3,
                  32'h0020C1B3, 32'hFFF00293, 32'h12345097, 32'h123450B7};
        pcs   = '{32'h100, 32'h104, 32'h108, 32'h10C,
                  32'h110, 32'h114, 32'h200, 32'h204};
        ops   = '{3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3};
        for (int i = 0; i < 8; i++) begin
            e = model(words[i], pcs[i], ok);
            send(words[i], pcs[i], 1'b0, xc);
            checks++;
            if (dut_v !== e || aluop !== ops[i] || ex_en !== 1'b0 ||
                inst_ready !== 1'b0 || illegal !== 1'b0) begin
                errors++;
                $display("FAIL dir_decode[%0d]: got %h aluop=%0d ex=%b rdy=%b, want %h aluop=%0d ex=0 rdy=0",
                         i, dut_v, aluop, ex_en, inst_ready, e, ops[i]);
            end
            k = 0;
            while (!ex_en && k < 10) begin
                @(negedge clk);
                k++;
            end
            checks++;
            if (k !== 2 || dut_v !== e) begin
                errors++;
                $display("FAIL dir_latency[%0d]: ex_en after %0d cycles, want 2", i, k);
            end
            @(negedge clk);
            checks++;
            if (ex_en !== 1'b0 || inst_ready !== 1'b1 || dut_v !== e) begin
                errors++;
                $display("FAIL dir_after[%0d]: ex=%b rdy=%b out=%h, want ex=0 rdy=1 out=%h",
                         i, ex_en, inst_ready, dut_v, e);
            end
            last = e;
        end
        checks++;
        if (pc !== 32'h204 || imm !== 32'h12345000 || pc_en !== 1'b0) begin
            errors++;
            $display("FAIL lui_const: pc=%h imm=%h pc_en=%b want 204 12345000 0", pc, imm, pc_en);
        end
    endtask

    task automatic test_illegal();
        int xc;
        bit seen;
        send(32'h00000073, 32'h300, 1'b0, xc);
        checks++;
        if (illegal !== 1'b1 || inst_ready !== 1'b1 || ex_en !== 1'b0 || dut_v !== last) begin
            errors++;
            $display("FAIL ecall: ill=%b rdy=%b ex=%b out=%h, want 1 1 0 out=%h",
                     illegal, inst_ready, ex_en, dut_v, last);
        end
        seen = 1'b0;
        @(negedge clk);
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL ecall_pulse_width: ill=%b want 0", illegal);
        end
        for (int i = 0; i < 4; i++) begin
            seen |= ex_en;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL ecall_issue: ex_en=1 seen, want none");
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [31:0] p;
        logic [6:0]  f7;
        dec_t e;
        bit   ok;
        int   sel;
        int   xc;
        int   k;
        for (int i = 0; i < 60; i++) begin
            w   = $urandom;
            p   = $urandom & 32'hFFFF_FFFC;
            sel = $urandom_range(0, 5);
            case ($urandom_range(0, 2))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            case (sel)
                0: begin w[6:0] = 7'h33; w[31:25] = f7; end
                1: w[6:0] = 7'h13;
                2: w[6:0] = 7'h37;
                3: w[6:0] = 7'h17;
                default: ;
            endcase
            e = model(w, p, ok);
            send(w, p, 1'b0, xc);
            if (ok) begin
                checks++;
                if (dut_v !== e || illegal !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_decode[%0d] w=%h: got %h ill=%b, want %h ill=0",
                             i, w, dut_v, illegal, e);
                end
                k = 0;
                while (!ex_en && k < 10) begin
                    @(negedge clk);
                    k++;
                end
                checks++;
                if (k !== 2) begin
                    errors++;
                    $display("FAIL rnd_latency[%0d]: %0d cycles, want 2", i, k);
                end
                @(negedge clk);
                last = e;
            end else begin
                checks++;
                if (illegal !== 1'b1 || dut_v !== last || inst_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL rnd_illegal[%0d] w=%h: ill=%b rdy=%b out=%h, want 1 1 %h",
                             i, w, illegal, inst_ready, dut_v, last);
                end
                @(negedge clk);
                checks++;
                if (illegal !== 1'b0 || ex_en !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_illegal_end[%0d]: ill=%b ex=%b, want 0 0", i, illegal, ex_en);
                end
            end
        end
    endtask

    task automatic test_hold();
        dec_t e;
        bit   ok;
        int   xc;
        int   k;
        e    = model(32'h00A50533, 32'h500, ok);
        hold = 1'b1;
        send(32'h00A50533, 32'h500, 1'b0, xc);
        k = 0;
        while (!ex_en && k < 15) begin
            if (k == 5) hold = 1'b0;
            @(negedge clk);
            k++;
        end
        hold = 1'b0;
        checks++;
        if (k !== 7 || dut_v !== e) begin
            errors++;
            $display("FAIL hold5: ex_en after %0d cycles out=%h, want 7 out=%h", k, dut_v, e);
        end
        @(negedge clk);
        checks++;
        if (ex_en !== 1'b0) begin
            errors++;
            $display("FAIL hold_pulse_width: ex=%b want 0", ex_en);
        end
        last = e;
    endtask

    task automatic test_flush();
        dec_t e;
        bit   ok;
        bit   seen;
        int   xc;
        e    = model(32'h402081B3, 32'h600, ok);
        hold = 1'b1;
        send(32'h402081B3, 32'h600, 1'b0, xc);
        flush = 1'b1;
        seen  = ex_en;
        @(negedge clk);
        flush = 1'b0;
        hold  = 1'b0;
        checks++;
        if (inst_ready !== 1'b1 || dut_v !== e) begin
            errors++;
            $display("FAIL flush_ready: rdy=%b out=%h, want 1 out=%h", inst_ready, dut_v, e);
        end
        for (int i = 0; i < 5; i++) begin
            seen |= ex_en;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_pulse: ex_en=1 seen, want none");
        end
        last = e;
    endtask

    task automatic test_back_to_back();
        dec_t ea;
        dec_t eb;
        bit   ok;
        int   xa;
        int   xb;
        int   k;
        ea = model(32'h002081B3, 32'h400, ok);
        eb = model(32'h0020C1B3, 32'h404, ok);
        send(32'h002081B3, 32'h400, 1'b1, xa);
        inst    = 32'h0020C1B3;
        inst_pc = 32'h404;
        @(negedge clk);
        checks++;
        if (dut_v !== ea) begin
            errors++;
            $display("FAIL b2b_no_early_xfer: out=%h want %h", dut_v, ea);
        end
        send(32'h0020C1B3, 32'h404, 1'b0, xb);
        checks++;
        if (xb - xa !== 3 || dut_v !== eb) begin
            errors++;
            $display("FAIL b2b_spacing: %0d cycles out=%h, want 3 out=%h", xb - xa, dut_v, eb);
        end
        k = 0;
        while (!ex_en && k < 10) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k !== 2) begin
            errors++;
            $display("FAIL b2b_latency: %0d cycles, want 2", k);
        end
        @(negedge clk);
        last = eb;
    endtask

    task automatic test_rst_fire();
        int xc;
        int k;
        send(32'h002081B3, 32'h700, 1'b0, xc);
        k = 0;
        while (!ex_en && k < 10) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (ex_en !== 1'b1) begin
            errors++;
            $display("FAIL rst_fire_setup: ex=%b want 1", ex_en);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (ex_en !== 1'b0 || dut_v !== '0 || inst_ready !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL rst_fire: ex=%b out=%h rdy=%b ill=%b, want all 0",
                     ex_en, dut_v, inst_ready, illegal);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (inst_ready !== 1'b1 || ex_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_fire_recover: rdy=%b ex=%b, want 1 0", inst_ready, ex_en);
        end
        last = '0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_random();
        test_hold();
        test_flush();
        test_back_to_back();
        test_rst_fire();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
